// File: rtl/ext_pipe_pkg.sv
// Shared CPU load/immediate extension definitions: mode encodings and
// the natural access width of each mode.
package ext_pipe_pkg;

    typedef enum logic [2:0] {
        EXT_ZERO = 3'd0,
        EXT_SIGN = 3'd1,
        EXT_LUI  = 3'd2,
        EXT_LB   = 3'd3,
        EXT_LBU  = 3'd4,
        EXT_LH   = 3'd5,
        EXT_LHU  = 3'd6,
        EXT_WORD = 3'd7
    } ext_mode_e;

    // Immediate modes report one byte so that they can never be misaligned.
    function automatic int unsigned lane_bytes(input ext_mode_e mode,
                                               input int unsigned word_bytes);
        int unsigned n;
        case (mode)
            EXT_LH, EXT_LHU: n = 2;
            EXT_WORD:        n = word_bytes;
            default:         n = 1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ext_lane_sel.sv
// Combinational lane select and sign/zero extension of an immediate or a
// loaded word, with alignment fault detection.
module ext_lane_sel
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [2:0]                  mode,
    input  logic [IMM_W-1:0]            imm,
    input  logic [DATA_W-1:0]           data,
    input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
    output logic [DATA_W-1:0]           ext_data,
    output logic                        misalign
);

    localparam int AW         = $clog2(DATA_W/8);
    localparam int WORD_BYTES = DATA_W / 8;

    ext_mode_e               mode_e;
    logic signed [7:0]       byte_s;
    logic signed [15:0]      half_s;
    logic signed [IMM_W-1:0] imm_s;
    logic [AW-1:0]           lane_mask;

    assign mode_e = ext_mode_e'(mode);
    assign imm_s  = imm;
    // Halfword lane index is addr_lo>>1, so the low offset bit is dropped.
    assign byte_s = 8'(data >> {addr_lo, 3'b000});
    assign half_s = 16'(data >> {addr_lo[AW-1:1], 4'b0000});

    assign lane_mask = AW'(lane_bytes(mode_e, WORD_BYTES) - 1);
    assign misalign  = |(addr_lo & lane_mask);

    always_comb begin
        ext_data = data;
        case (mode_e)
            EXT_ZERO: ext_data = DATA_W'(imm);
            EXT_SIGN: ext_data = DATA_W'(imm_s);
            EXT_LUI:  ext_data = {imm, (DATA_W-IMM_W)'(0)};
            EXT_LB:   ext_data = DATA_W'(byte_s);
            EXT_LBU:  ext_data = DATA_W'($unsigned(byte_s));
            EXT_LH:   ext_data = DATA_W'(half_s);
            EXT_LHU:  ext_data = DATA_W'($unsigned(half_s));
            EXT_WORD: ext_data = data;
            default:  ext_data = data;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// One-stage valid/ready extension pipeline with flush and a saturating
// count of accepted misaligned requests.
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  mode,
    input  logic [IMM_W-1:0]            imm,
    input  logic [DATA_W-1:0]           data,
    input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_misalign,
    output logic [CNT_W-1:0]            misalign_cnt
);

    logic [DATA_W-1:0] ext_data_p0;
    logic              misalign_p0;
    logic              accept_p0;
    logic [DATA_W-1:0] data_p1;
    logic              misalign_p1;
    logic              vld_p1;
    logic [CNT_W-1:0]  cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    ext_lane_sel #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_lane_sel (
        .mode     (mode),
        .imm      (imm),
        .data     (data),
        .addr_lo  (addr_lo),
        .ext_data (ext_data_p0),
        .misalign (misalign_p0)
    );

    assign in_ready  = !vld_p1 || out_ready;
    assign accept_p0 = in_valid && in_ready && !flush;

    // Stage p0 -> p1: result register, drained or replaced per handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            data_p1     <= '0;
            misalign_p1 <= 1'b0;
            cnt_p1      <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1      <= 1'b1;
            data_p1     <= ext_data_p0;
            misalign_p1 <= misalign_p0;
            if (misalign_p0) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid    = vld_p1;
    assign out_data     = data_p1;
    assign out_misalign = misalign_p1;
    assign misalign_cnt = cnt_p1;

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the output datapath width; legal values are 32 or 64.
REQ-002 SHALL have parameter IMM_W, default 16, meaning the immediate field width; IMM_W < DATA_W.
REQ-003 SHALL have parameter CNT_W, default 8, meaning the width of the saturating misalignment counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, stage can accept a request.
REQ-008 SHALL have port mode, input, 3, extension mode per REQ-016.
REQ-009 SHALL have port imm, input, IMM_W, immediate field.
REQ-010 SHALL have port data, input, DATA_W, loaded memory word.
REQ-011 SHALL have port addr_lo, input, clog2(DATA_W/8), byte offset within the word.
REQ-012 SHALL have port flush, input, 1, discards the held result and any same-cycle request.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DATA_W), out_misalign (output, 1): the result handshake, result value and alignment fault flag.
REQ-014 SHALL have port misalign_cnt, output, CNT_W, count of accepted misaligned requests.

Function
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally, with no dependence on in_valid.
REQ-016 SHALL decode mode as follows. 0 ZERO: zero-extend imm. 1 SIGN: sign-extend imm. 2 LUI: {imm, zeros}. 3 LB: sign-extend byte lane addr_lo of data. 4 LBU: zero-extend that byte. 5 LH: sign-extend halfword lane addr_lo>>1. 6 LHU: zero-extend that halfword. 7 WORD: data unchanged. Lanes are little-endian (lane 0 = bits 7:0).
REQ-017 SHALL accept a request when in_valid && in_ready && !flush; on accept, register out_data, out_misalign and out_valid=1 on the next edge (latency 1 cycle).
REQ-018 SHALL assert out_misalign for LH/LHU when addr_lo[0]=1, and for WORD when addr_lo!=0; out_data is still computed from the truncated lane.
REQ-019 SHALL hold out_data, out_misalign and out_valid stable while out_valid && !out_ready (stall).
REQ-020 SHALL clear out_valid on the next edge when out_valid && out_ready && no new accept.
REQ-021 SHALL replace the held result with the new one, keeping out_valid=1, on an edge with both a drain and an accept (back-to-back throughput 1 per cycle).
REQ-022 SHALL clear out_valid on the next edge when flush=1, regardless of stall or in_valid; the flushed request is not counted.
REQ-023 SHALL increment misalign_cnt by 1 for each accepted request with a misalignment, saturating at 2^CNT_W-1 with no wrap.
REQ-024 SHALL ignore addr_lo for modes 0-2 and never flag misalignment for them.

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, set out_valid=0, out_data=0, out_misalign=0 and misalign_cnt=0; reset overrides flush and accept.
REQ-026 SHALL discard an in-flight or stalled result on reset mid-operation; the first accept after rst_n returns high behaves as from idle.

Structure
REQ-027 SHALL take the mode encodings (EXT_ZERO..EXT_WORD) and the lane-width function from the shared CPU package, not from local literals.
REQ-028 SHALL contain one combinational sub-module, ext_lane_sel, that performs lane select and extension for REQ-016/REQ-018; the handshake register and counter live in ext_pipe.

Verification
REQ-029 SHALL cover: SIGN with imm=16'h8001 -> out_data 32'hFFFF8001 one cycle later; ZERO with the same imm -> 32'h00008001; LUI with imm=16'h1234 -> 32'h12340000.
REQ-030 SHALL cover: LB with data=32'h80FF7F01, addr_lo=3 -> 32'hFFFFFF80; LBU with addr_lo=2 -> 32'h000000FF; LH with addr_lo=2 -> 32'hFFFF80FF.
REQ-031 SHALL cover: LHU with addr_lo=1 -> out_misalign=1 and misalign_cnt 0->1; WORD with addr_lo=0 -> out_misalign=0.
REQ-032 SHALL cover: out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0 and out_data unchanged; then out_ready=1 with a new request -> the new result appears on the next edge with out_valid staying 1.
REQ-033 SHALL cover: flush=1 while stalled with in_valid=1 -> out_valid=0 next cycle and misalign_cnt unchanged; 260 misaligned accepts with CNT_W=8 -> misalign_cnt=255.
REQ-034 SHALL cover: rst_n=0 for 1 cycle while stalled -> all outputs 0 on the next edge.
